// File: rtl/komandara_bus_pkg.sv
// Shared definitions for the komandara request/grant bus blocks.
// Holds the mux FSM encoding and the owner-index width rule.
package komandara_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RSP  = 2'd2
    } bus_mux_state_e;

    // A single master still needs a one-bit owner index.
    function automatic int unsigned owner_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/komandara_arbiter.sv
// N-way arbiter: round-robin or fixed priority (lowest index wins).
// The round-robin pointer rotates only on advance_i, past the last winner.
module komandara_arbiter
    import komandara_bus_pkg::*;
#(
    parameter int unsigned N_MST       = 2,
    parameter bit          ROUND_ROBIN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_MST-1:0] req_i,
    input  logic             advance_i,
    output logic [N_MST-1:0] gnt_o
);

    localparam int unsigned IdxW = owner_w(N_MST);

    logic [IdxW-1:0]  ptr_q, ptr_d;
    logic [IdxW-1:0]  last_q, last_d;
    logic [IdxW-1:0]  gnt_idx;
    logic [N_MST-1:0] mask, masked_req, pick_req;
    logic             found;

    always_comb begin
        for (int i = 0; i < N_MST; i++) begin
            mask[i] = ROUND_ROBIN ? (IdxW'(i) >= ptr_q) : 1'b1;
        end
        masked_req = req_i & mask;
        // Requesters at or above the pointer go first, then wrap to the bottom.
        pick_req = (|masked_req) ? masked_req : req_i;
    end

    always_comb begin
        gnt_o   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < N_MST; i++) begin
            if (!found && pick_req[i]) begin
                gnt_o[i] = 1'b1;
                gnt_idx  = IdxW'(i);
                found    = 1'b1;
            end
        end
    end

    // Remember the winner: the grant is gated off by the time advance_i arrives.
    always_comb begin
        last_d = found ? gnt_idx : last_q;
        ptr_d  = ptr_q;
        if (advance_i) begin
            ptr_d = (last_q == IdxW'(N_MST - 1)) ? '0 : last_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q  <= '0;
            last_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/komandara_bus_mux.sv
// N-master to 1-slave request/grant mux with a single outstanding transaction.
// The owner is locked from request to response; the arbiter rotates per completion.
module komandara_bus_mux
    import komandara_bus_pkg::*;
#(
    parameter int unsigned N_MST       = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter bit          ROUND_ROBIN = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [N_MST-1:0]             m_req_i,
    input  logic [N_MST*ADDR_W-1:0]      m_addr_i,
    input  logic [N_MST-1:0]             m_we_i,
    input  logic [N_MST*(DATA_W/8)-1:0]  m_be_i,
    input  logic [N_MST*DATA_W-1:0]      m_wdata_i,
    output logic [N_MST-1:0]             m_gnt_o,
    output logic [N_MST-1:0]             m_rvalid_o,
    output logic [DATA_W-1:0]            m_rdata_o,
    output logic                         m_err_o,
    output logic                         s_req_o,
    output logic [ADDR_W-1:0]            s_addr_o,
    output logic                         s_we_o,
    output logic [DATA_W/8-1:0]          s_be_o,
    output logic [DATA_W-1:0]            s_wdata_o,
    input  logic                         s_gnt_i,
    input  logic                         s_rvalid_i,
    input  logic [DATA_W-1:0]            s_rdata_i,
    input  logic                         s_err_i
);

    localparam int unsigned OwnW = owner_w(N_MST);
    localparam int unsigned BeW  = DATA_W / 8;

    bus_mux_state_e   state_q, state_d;
    logic [OwnW-1:0]  r_owner_q, r_owner_d;
    logic [OwnW-1:0]  arb_idx, sel;
    logic [N_MST-1:0] arb_req, arb_gnt;
    logic             arb_adv;
    logic             gnt_hit, rsp_hit;

    assign arb_req = (state_q == IDLE) ? m_req_i : '0;
    assign arb_adv = (state_q == RSP) && s_rvalid_i;

    komandara_arbiter #(
        .N_MST       (N_MST),
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_arbiter (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (arb_req),
        .advance_i (arb_adv),
        .gnt_o     (arb_gnt)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (arb_gnt[i]) begin
                arb_idx = OwnW'(i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            r_owner_q <= '0;
        end else begin
            state_q   <= state_d;
            r_owner_q <= r_owner_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        r_owner_d = r_owner_q;
        unique case (state_q)
            IDLE: begin
                if (|m_req_i) begin
                    r_owner_d = arb_idx;
                    state_d   = s_gnt_i ? RSP : ADDR;
                end
            end
            ADDR: begin
                if (s_gnt_i) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                if (s_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_req_o = 1'b0;
        sel     = r_owner_q;
        rsp_hit = 1'b0;
        unique case (state_q)
            IDLE: begin
                s_req_o = |m_req_i;
                sel     = arb_idx;
            end
            ADDR:    s_req_o = 1'b1;
            RSP:     rsp_hit = s_rvalid_i;
            default: s_req_o = 1'b0;
        endcase
        gnt_hit = s_req_o && s_gnt_i;

        m_gnt_o    = '0;
        m_rvalid_o = '0;
        s_addr_o   = '0;
        s_we_o     = 1'b0;
        s_be_o     = '0;
        s_wdata_o  = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (sel == OwnW'(i)) begin
                m_gnt_o[i]    = gnt_hit;
                m_rvalid_o[i] = rsp_hit;
                if (s_req_o) begin
                    s_addr_o  = m_addr_i[i*ADDR_W +: ADDR_W];
                    s_we_o    = m_we_i[i];
                    s_be_o    = m_be_i[i*BeW +: BeW];
                    s_wdata_o = m_wdata_i[i*DATA_W +: DATA_W];
                end
            end
        end

        m_rdata_o = rsp_hit ? s_rdata_i : '0;
        m_err_o   = rsp_hit & s_err_i;
    end

endmodule

// File: tb/tb_komandara_bus_mux.sv
// Directed and randomized bench for komandara_bus_mux with two masters.
// A round-robin and a fixed-priority instance share all inputs.
module tb_komandara_bus_mux;

    localparam int NM = 2;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [1:0]  m_req = '0;
    logic [63:0] m_addr = '0;
    logic [1:0]  m_we = '0;
    logic [7:0]  m_be = '0;
    logic [63:0] m_wdata = '0;
    logic        s_gnt = 1'b0;
    logic        s_rvalid = 1'b0;
    logic [31:0] s_rdata = '0;
    logic        s_err = 1'b0;

    logic [1:0]  m_gnt, m_rvalid, fp_gnt, fp_rvalid;
    logic [31:0] m_rdata, fp_rdata;
    logic        m_err, fp_err;
    logic        s_req, fp_s_req;
    logic [31:0] s_addr, fp_s_addr, s_wdata, fp_s_wdata;
    logic        s_we, fp_s_we;
    logic [3:0]  s_be, fp_s_be;

    int checks = 0;
    int errors = 0;
    int rr_next = 0;

    always #5 clk = ~clk;

    komandara_bus_mux #(.N_MST(2), .ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .m_req_i(m_req), .m_addr_i(m_addr), .m_we_i(m_we),
        .m_be_i(m_be), .m_wdata_i(m_wdata), .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid),
        .m_rdata_o(m_rdata), .m_err_o(m_err), .s_req_o(s_req), .s_addr_o(s_addr),
        .s_we_o(s_we), .s_be_o(s_be), .s_wdata_o(s_wdata), .s_gnt_i(s_gnt),
        .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .s_err_i(s_err)
    );

    komandara_bus_mux #(.N_MST(2), .ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(1'b0)) dut_fp (
        .clk_i(clk), .rst_ni(rst_ni), .m_req_i(m_req), .m_addr_i(m_addr), .m_we_i(m_we),
        .m_be_i(m_be), .m_wdata_i(m_wdata), .m_gnt_o(fp_gnt), .m_rvalid_o(fp_rvalid),
        .m_rdata_o(fp_rdata), .m_err_o(fp_err), .s_req_o(fp_s_req), .s_addr_o(fp_s_addr),
        .s_we_o(fp_s_we), .s_be_o(fp_s_be), .s_wdata_o(fp_s_wdata), .s_gnt_i(s_gnt),
        .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .s_err_i(s_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Round-robin reference: first requester at or after the preferred master.
    function automatic int model_winner(input logic [1:0] req);
        for (int k = 0; k < NM; k++) begin
            int m;
            m = (rr_next + k) % NM;
            if (req[m]) return m;
        end
        return 0;
    endfunction

    task automatic check_quiet(input string tag);
        chk({tag, ".s_req"}, 64'(s_req), 64'd0);
        chk({tag, ".m_gnt"}, 64'(m_gnt), 64'd0);
        chk({tag, ".m_rvalid"}, 64'(m_rvalid), 64'd0);
        chk({tag, ".s_addr"}, 64'(s_addr), 64'd0);
        chk({tag, ".s_we_be"}, 64'({s_we, s_be}), 64'd0);
        chk({tag, ".s_wdata"}, 64'(s_wdata), 64'd0);
        chk({tag, ".m_rdata"}, 64'(m_rdata), 64'd0);
        chk({tag, ".m_err"}, 64'(m_err), 64'd0);
    endtask

    task automatic rand_payload();
        m_addr  = {$urandom, $urandom};
        m_we    = 2'($urandom_range(0, 3));
        m_be    = 8'($urandom_range(0, 255));
        m_wdata = {$urandom, $urandom};
    endtask

    // One full transaction; late bits join the request after the first cycle.
    task automatic do_txn(input logic [1:0] req, input logic [1:0] late, input int gw,
                          input int rw, input logic err, input logic [31:0] rd);
        int         win;
        logic [1:0] oh, fp_oh;
        win   = model_winner(req);
        oh    = 2'b01 << win;
        fp_oh = req[0] ? 2'b01 : 2'b10;
        for (int c = 0; c <= gw; c++) begin
            m_req = (c == 0) ? req : (req | late);
            s_gnt = (c == gw);
            #2;
            chk("req.s_req", 64'(s_req), 64'd1);
            chk("req.s_addr", 64'(s_addr), 64'(m_addr[win*32 +: 32]));
            chk("req.s_we_be", 64'({s_we, s_be}), 64'({m_we[win], m_be[win*4 +: 4]}));
            chk("req.s_wdata", 64'(s_wdata), 64'(m_wdata[win*32 +: 32]));
            chk("req.m_gnt", 64'(m_gnt), (c == gw) ? 64'(oh) : 64'd0);
            if (c == gw) chk("req.fp_gnt", 64'(fp_gnt), 64'(fp_oh));
            step();
        end
        m_req = '0;
        s_gnt = 1'b0;
        for (int c = 0; c <= rw; c++) begin
            s_rvalid = (c == rw);
            s_rdata  = (c == rw) ? rd : $urandom;
            s_err    = (c == rw) ? err : 1'b1;
            #2;
            chk("rsp.s_req", 64'(s_req), 64'd0);
            chk("rsp.m_gnt", 64'(m_gnt), 64'd0);
            chk("rsp.m_rvalid", 64'(m_rvalid), (c == rw) ? 64'(oh) : 64'd0);
            chk("rsp.m_rdata", 64'(m_rdata), (c == rw) ? 64'(rd) : 64'd0);
            chk("rsp.m_err", 64'(m_err), (c == rw) ? 64'(err) : 64'd0);
            step();
        end
        rr_next  = (win + 1) % NM;
        s_rvalid = 1'b0;
        s_rdata  = $urandom;
        s_err    = 1'b1;
        #2;
        chk("post.m_rvalid", 64'(m_rvalid), 64'd0);
        chk("post.m_err", 64'(m_err), 64'd0);
        chk("post.m_rdata", 64'(m_rdata), 64'd0);
        step();
        s_err   = 1'b0;
        s_rdata = '0;
    endtask

    task automatic spurious();
        m_req    = '0;
        s_rvalid = 1'b1;
        s_rdata  = $urandom | 32'h1;
        s_err    = 1'b1;
        #2;
        check_quiet("spur");
        step();
        s_rvalid = 1'b0;
        s_rdata  = '0;
        s_err    = 1'b0;
    endtask

    initial begin
        #12;
        check_quiet("reset");
        step();
        rst_ni = 1'b1;
        step();
        check_quiet("idle");

        // Fairness: both masters request continuously.
        for (int t = 0; t < 6; t++) begin
            rand_payload();
            do_txn(2'b11, 2'b00, 0, 0, 1'b0, $urandom);
        end

        // Single master, zero-wait write.
        rand_payload();
        m_addr[31:0]  = 32'h100;
        m_we[0]       = 1'b1;
        m_be[3:0]     = 4'hF;
        m_wdata[31:0] = 32'hDEADBEEF;
        do_txn(2'b01, 2'b00, 0, 0, 1'b0, $urandom);

        // Address-phase lock: M0 arrives while M1 waits for the grant.
        rand_payload();
        do_txn(2'b10, 2'b01, 3, 0, 1'b0, $urandom);
        rand_payload();
        do_txn(2'b11, 2'b00, 0, 1, 1'b0, $urandom);

        // Error response to an M1 read.
        rand_payload();
        m_we[1] = 1'b0;
        do_txn(2'b10, 2'b00, 0, 0, 1'b1, 32'h12345678);

        spurious();
        rand_payload();
        do_txn(2'b11, 2'b00, 0, 0, 1'b0, $urandom);

        // Reset while waiting for the response.
        rand_payload();
        m_req = 2'b10;
        s_gnt = 1'b1;
        step();
        m_req    = '0;
        s_gnt    = 1'b0;
        s_rvalid = 1'b1;
        s_rdata  = 32'hCAFE0001;
        s_err    = 1'b1;
        rst_ni   = 1'b0;
        #2;
        check_quiet("midrst");
        step();
        rst_ni   = 1'b1;
        s_rvalid = 1'b0;
        s_rdata  = '0;
        s_err    = 1'b0;
        rr_next  = 0;
        step();
        rand_payload();
        do_txn(2'b11, 2'b00, 0, 0, 1'b0, $urandom);

        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 3) == 0) spurious();
            rand_payload();
            do_txn(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/komandara_bus_mux.md
# komandara_bus_mux

N-master to 1-slave request/grant bus multiplexer with a single outstanding transaction. It sits directly upstream of a shared slave port, such as a data RAM or peripheral crossbar leg. It instantiates the shared arbiter to pick a master and locks that choice for the full transaction. It pulses the arbiter advance when the response returns, so round-robin fairness rotates per completed transaction.

## Interface
- N_MST, default 2: number of masters, at least 1.
- ADDR_W, default 32: address width.
- DATA_W, default 32: data width, a multiple of 8.
- ROUND_ROBIN, default 1: 1 selects round-robin, 0 selects fixed priority (lower index wins).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- m_req_i  in  N_MST  per-master request; held until granted
- m_addr_i  in  N_MST×ADDR_W  per-master address
- m_we_i  in  N_MST  per-master write enable
- m_be_i  in  N_MST×DATA_W/8  per-master byte enables
- m_wdata_i  in  N_MST×DATA_W  per-master write data
- m_gnt_o  out  N_MST  per-master grant, one-hot or zero
- m_rvalid_o  out  N_MST  per-master response valid, one-hot or zero
- m_rdata_o  out  DATA_W  response data, broadcast to all masters
- m_err_o  out  1  response error, broadcast to all masters
- s_req_o  out  1  slave request
- s_addr_o, s_we_o, s_be_o, s_wdata_o  out  ADDR_W, 1, DATA_W/8, DATA_W  slave request payload
- s_gnt_i  in  1  slave accepts request
- s_rvalid_i  in  1  slave response valid
- s_rdata_i  in  DATA_W  slave response data
- s_err_i  in  1  slave response error

## Operation
- States:
  - IDLE: no transaction.
  - ADDR: request issued but not yet accepted; owner locked.
  - RSP: accepted; waiting for the response.
- IDLE:
  - If |m_req_i, the owner is the arbiter grant. s_req_o=1 and the payload is taken from that master, combinationally.
  - If s_gnt_i is high the same cycle, m_gnt_o[owner]=1 and the next state is RSP.
  - Otherwise the owner index is registered in r_owner and the next state is ADDR.
- ADDR:
  - The payload is taken from r_owner and s_req_o=1, regardless of new higher-priority requests.
  - On s_gnt_i: m_gnt_o[r_owner]=1, next state RSP.
- RSP:
  - s_req_o=0 and m_gnt_o=0.
  - On s_rvalid_i: m_rvalid_o[r_owner]=1; m_rdata_o=s_rdata_i and m_err_o=s_err_i pass through combinationally.
  - The arbiter advance_i is pulsed the same cycle, then the next state is IDLE.
- When IDLE goes straight to RSP, r_owner is loaded with the arbiter grant index that cycle.
- Payload outputs are zero whenever s_req_o=0.
- m_rdata_o is zero whenever no m_rvalid_o bit is set; m_err_o is likewise zero.
- s_rvalid_i in IDLE or ADDR is ignored: it is not forwarded and does not advance the arbiter.
- s_gnt_i while s_req_o=0 is ignored.
- Arbiter advance_i is exactly the RSP response-accept pulse.
- Fixed-priority mode: masters can starve; this is accepted behaviour.

## Timing
- Reset values:
  - state=IDLE, r_owner=0.
  - All outputs are 0 while m_req_i=0: s_req_o, m_gnt_o, m_rvalid_o, payload, m_rdata_o, m_err_o.
- Request path m_req_i→s_req_o is combinational, with zero-cycle latency.
- Minimum transaction length is 2 cycles: grant in cycle 0, rvalid in cycle 1.
- The next request can be issued in the cycle after rvalid; there is no back-to-back overlap.
- Reset asserted mid-transaction forces IDLE immediately. The in-flight response is dropped; the slave must be reset with the same reset.
- N_MST=1: the owner index is always 0 and r_owner is 1 bit wide.

## Structure
- The shared package komandara_bus_pkg holds:
  - the bus_mux_state_e enum (IDLE, ADDR, RSP);
  - the owner index width localparam rule: $clog2(N_MST), minimum 1.
- Sub-module: one komandara_arbiter instance, with:
  - req_i=m_req_i, gated to 0 outside IDLE;
  - advance_i=RSP&s_rvalid_i;
  - ROUND_ROBIN passed through.
- Grant-to-index encoding is local logic.

## Test plan
- Single master, zero-wait slave: M0 writes addr 0x100, data 0xDEADBEEF, be 0xF, with s_gnt_i=1 in the same cycle. Required: m_gnt_o=01 that cycle, and m_rvalid_o=01 one cycle later when s_rvalid_i rises.
- Address-phase lock: M1 requests alone with s_gnt_i held low for 3 cycles, and M0 raises its request in cycle 1. Required: s_addr_o stays M1's address until the grant and m_gnt_o=10; M0 is served next.
- Round-robin fairness: M0 and M1 request continuously for 6 transactions. Required: grants alternate M0, M1, M0, M1, M0, M1. With ROUND_ROBIN=0, all six grants go to M0.
- Error response: M1 reads and the slave returns s_err_i=1 with s_rdata_i=0x12345678. Required: m_rvalid_o=10, m_err_o=1, m_rdata_o=0x12345678; m_err_o returns to 0 the next cycle.
- Spurious response: s_rvalid_i pulses while IDLE with no request. Required: no m_rvalid_o, and the next winner is unchanged.
- Reset mid-RSP: rst_ni pulses low while waiting for the response. Required: the design is IDLE, all outputs are 0, and the first grant after reset goes to M0.
